// File: rtl/copy_pkg.sv
// ============================================================================
// copy_pkg : shared types and codes for the byte copy sequencer
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package copy_pkg;

  typedef enum logic [1:0] {
    MODE_IMM  = 2'b00,
    MODE_CALC = 2'b01,
    MODE_COPY = 2'b10,
    MODE_COND = 2'b11
  } mode_e;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    EXEC = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    SEL_ZERO = 2'd0,
    SEL_IMM  = 2'd1,
    SEL_BUS  = 2'd2,
    SEL_IN   = 2'd3
  } bus_sel_e;

  localparam logic [2:0] CODE_IN  = 3'd6;
  localparam logic [2:0] CODE_OUT = 3'd7;

endpackage

`default_nettype wire

// File: rtl/copy_decoder.sv
// ============================================================================
// copy_decoder : combinational decode of a latched instruction into strobes
// Revision     : 1.0 - initial release
// ============================================================================
`default_nettype none

module copy_decoder
  import copy_pkg::*;
#(
  parameter int NUM_REGS = 6
) (
  input  logic [7:0]          instr,
  input  logic                in_valid,
  input  logic                out_ready,
  output logic [NUM_REGS-1:0] load,
  output logic [NUM_REGS-1:0] save,
  output logic [1:0]          bus_sel,
  output logic                fire,
  output logic                illegal,
  output logic                in_take,
  output logic                out_offer
);

  localparam logic [2:0] C_NUM_REGS = 3'(NUM_REGS);

  mode_e      w_mode;
  logic [2:0] w_src;
  logic [2:0] w_dst;
  logic       w_src_ok;
  logic       w_dst_ok;

  always_comb begin
    w_mode    = mode_e'(instr[7:6]);
    w_src     = instr[5:3];
    w_dst     = instr[2:0];
    w_src_ok  = (w_src != CODE_IN) | in_valid;
    w_dst_ok  = (w_dst != CODE_OUT) | out_ready;
    load      = '0;
    save      = '0;
    bus_sel   = SEL_ZERO;
    fire      = 1'b0;
    illegal   = 1'b0;
    in_take   = 1'b0;
    out_offer = 1'b0;

    case (w_mode)
      MODE_IMM: begin
        save[0] = 1'b1;
        bus_sel = SEL_IMM;
        fire    = 1'b1;
      end
      MODE_COPY: begin
        fire = w_src_ok & w_dst_ok;
        for (int i = 0; i < NUM_REGS; i++) begin
          if (w_src == 3'(i)) load[i] = 1'b1;
          if (w_dst == 3'(i)) save[i] = fire;
        end
        if (w_src < C_NUM_REGS)    bus_sel = SEL_BUS;
        else if (w_src == CODE_IN) bus_sel = SEL_IN;
        else                       bus_sel = SEL_ZERO;
        out_offer = (w_dst == CODE_OUT) & w_src_ok;
        // Input-to-output passthrough hands the consumer's ready straight upstream.
        if (w_src == CODE_IN)
          in_take = (w_dst == CODE_OUT) ? out_ready : fire;
      end
      default: begin
        illegal = 1'b1;
        fire    = 1'b1;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/byte_copy_sequencer.sv
// ============================================================================
// byte_copy_sequencer : accepts IMM/COPY instructions and moves one byte each
// Revision            : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_copy_sequencer
  import copy_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REGS   = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [7:0]            instr,
  output logic [NUM_REGS-1:0]   reg_load,
  output logic [NUM_REGS-1:0]   reg_save,
  input  logic [DATA_WIDTH-1:0] bus_in,
  output logic [DATA_WIDTH-1:0] bus_out,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  illegal
);

  state_e              r_state;
  logic [7:0]          r_instr;
  logic                w_exec;
  logic [NUM_REGS-1:0] w_load;
  logic [NUM_REGS-1:0] w_save;
  logic [1:0]          w_sel;
  logic                w_fire;
  logic                w_illegal;
  logic                w_in_take;
  logic                w_out_offer;
  logic [DATA_WIDTH-1:0] w_bus;

  copy_decoder #(
    .NUM_REGS (NUM_REGS)
  ) u_decoder (
    .instr     (r_instr),
    .in_valid  (in_valid),
    .out_ready (out_ready),
    .load      (w_load),
    .save      (w_save),
    .bus_sel   (w_sel),
    .fire      (w_fire),
    .illegal   (w_illegal),
    .in_take   (w_in_take),
    .out_offer (w_out_offer)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_instr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (instr_valid) begin
            r_instr <= instr;
            r_state <= EXEC;
          end
        end
        EXEC: begin
          if (w_fire) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_exec = (r_state == EXEC);

  // Strobes only exist in EXEC so a reset drops them in the same instant.
  always_comb begin
    w_bus = '0;
    if (w_exec) begin
      case (w_sel)
        SEL_IMM: w_bus = DATA_WIDTH'(r_instr[5:0]);
        SEL_BUS: w_bus = bus_in;
        SEL_IN:  w_bus = in_data;
        default: w_bus = '0;
      endcase
    end
  end

  assign instr_ready = (r_state == IDLE);
  assign reg_load    = w_exec ? w_load : '0;
  assign reg_save    = w_exec ? w_save : '0;
  assign bus_out     = w_bus;
  assign out_data    = w_bus;
  assign in_ready    = w_exec & w_in_take;
  assign out_valid   = w_exec & w_out_offer;
  assign illegal     = w_exec & w_illegal;

endmodule

`default_nettype wire

// File: tb/tb_byte_copy_sequencer.sv
// ============================================================================
// tb_byte_copy_sequencer : scoreboard bench with a modelled register bank
// Revision               : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_byte_copy_sequencer;

  logic       clk;
  logic       rst_n;
  logic       instr_valid;
  logic       instr_ready;
  logic [7:0] instr;
  logic [5:0] reg_load;
  logic [5:0] reg_save;
  logic [7:0] bus_in;
  logic [7:0] bus_out;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       illegal;

  int n_checks = 0;
  int n_pass   = 0;

  // {kind(1=out port), reg index, data}
  logic [12:0] sb[$];
  logic [7:0]  regs [6];
  logic [7:0]  gold [6];
  logic [3:0]  mon_idx;

  byte_copy_sequencer #(
    .DATA_WIDTH (8),
    .NUM_REGS   (6)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr       (instr),
    .reg_load    (reg_load),
    .reg_save    (reg_save),
    .bus_in      (bus_in),
    .bus_out     (bus_out),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .illegal     (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register bank model driven by the DUT strobes.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 6; i++) regs[i] <= 8'hA3 + 8'(i);
    end else begin
      for (int i = 0; i < 6; i++) if (reg_save[i]) regs[i] <= bus_out;
    end
  end

  always_comb begin
    bus_in = '0;
    for (int i = 0; i < 6; i++) if (reg_load[i]) bus_in = bus_in | regs[i];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic score(input logic [12:0] obs);
    if (sb.size() == 0) check("sb_unexpected", 32'(obs), 32'hDEAD);
    else                check("sb_transfer", 32'(obs), 32'(sb.pop_front()));
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (reg_save != '0) begin
        mon_idx = 4'hF;
        for (int i = 0; i < 6; i++) if (reg_save == 6'(1 << i)) mon_idx = 4'(i);
        score({1'b0, mon_idx, bus_out});
      end
      if (out_valid && out_ready) score({1'b1, 4'h0, out_data});
    end
  end

  task automatic push_save(input int d, input logic [7:0] v);
    sb.push_back({1'b0, 4'(d), v});
    gold[d] = v;
  endtask

  task automatic push_out(input logic [7:0] v);
    sb.push_back({1'b1, 4'h0, v});
  endtask

  // Offer an instruction; returns at posedge+1 of the first EXEC cycle.
  task automatic send(input logic [7:0] x);
    int n;
    n = 0;
    instr       = x;
    instr_valid = 1'b1;
    while (!instr_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!instr_ready) check("instr_ready_timeout", 32'(instr_ready), 32'd1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
  endtask

  task automatic step;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_instr_ready"}, 32'(instr_ready), 32'd1);
    check({tag, "_strobes"}, 32'({reg_load, reg_save}), 32'd0);
    check({tag, "_bus_out"}, 32'(bus_out), 32'd0);
    check({tag, "_ports"}, 32'({in_ready, out_valid, illegal}), 32'd0);
  endtask

  initial begin
    rst_n       = 1'b0;
    instr_valid = 1'b0;
    instr       = '0;
    in_valid    = 1'b0;
    in_data     = '0;
    out_ready   = 1'b0;
    for (int i = 0; i < 6; i++) gold[i] = 8'hA3 + 8'(i);

    #12;
    check_reset_outputs("rst");
    step;
    rst_n = 1'b1;

    // IMM 42 into reg0
    push_save(0, 8'd42);
    send(8'b00_101010);
    @(negedge clk);
    check("imm_save", 32'(reg_save), 32'b000001);
    check("imm_bus", 32'(bus_out), 32'd42);
    check("imm_busy", 32'(instr_ready), 32'd0);
    step;
    check("imm_ready_back", 32'(instr_ready), 32'd1);

    // COPY 2->4
    push_save(4, gold[2]);
    send(8'b10_010_100);
    @(negedge clk);
    check("c24_load", 32'(reg_load), 32'b000100);
    check("c24_save", 32'(reg_save), 32'b010000);
    check("c24_bus", 32'(bus_out), 32'hA5);
    step;

    // COPY 3->3 keeps the value
    push_save(3, gold[3]);
    send(8'b10_011_011);
    @(negedge clk);
    check("c33_strobes", 32'({reg_load, reg_save}), 32'b001000_001000);
    step;

    // COPY 6->1 with delayed input
    push_save(1, 8'h3C);
    send(8'b10_110_001);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("c61_wait", 32'({reg_save, in_ready}), 32'd0);
      step;
    end
    in_valid = 1'b1;
    in_data  = 8'h3C;
    @(negedge clk);
    check("c61_fire", 32'({reg_save, in_ready}), 32'b000010_1);
    step;
    in_valid = 1'b0;
    @(negedge clk);
    check("c61_after", 32'({reg_save, in_ready}), 32'd0);
    step;

    // COPY 5->7 with back-pressure
    push_out(gold[5]);
    send(8'b10_101_111);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check("c57_hold", 32'({out_valid, out_data}), 32'({1'b1, gold[5]}));
      check("c57_load", 32'(reg_load), 32'b100000);
      step;
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("c57_take", 32'(out_valid), 32'd1);
    step;
    out_ready = 1'b0;
    @(negedge clk);
    check("c57_done", 32'(out_valid), 32'd0);
    step;

    // Illegal mode
    send(8'b01_000000);
    @(negedge clk);
    check("ill_pulse", 32'(illegal), 32'd1);
    check("ill_quiet", 32'({reg_load, reg_save, out_valid, in_ready}), 32'd0);
    step;
    @(negedge clk);
    check("ill_end", 32'({illegal, instr_ready}), 32'b01);
    step;

    // COPY 6->7 passthrough
    in_valid  = 1'b1;
    out_ready = 1'b1;
    in_data   = 8'h77;
    push_out(8'h77);
    send(8'b10_110_111);
    @(negedge clk);
    check("c67_pass", 32'({in_ready, out_valid, out_data}), 32'({2'b11, 8'h77}));
    step;
    in_valid  = 1'b0;
    @(negedge clk);
    check("c67_idle", 32'(instr_ready), 32'd1);
    step;

    // COPY 0->7 shows the immediate landed in reg0
    push_out(gold[0]);
    send(8'b10_000_111);
    @(negedge clk);
    check("c07_data", 32'(out_data), 32'd42);
    step;
    out_ready = 1'b0;

    // Reset in the middle of a stalled COPY 6->0
    send(8'b10_110_000);
    @(negedge clk);
    check("c60_stall", 32'({reg_save, instr_ready}), 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midrst");
    in_valid = 1'b1;
    step;
    step;
    rst_n = 1'b1;
    step;
    @(negedge clk);
    check("post_rst_nosave", 32'(reg_save), 32'd0);
    in_valid = 1'b0;
    step;

    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
